// File: rtl/ctrl_pkg.sv
// Shared encodings and control bundles for the pipelined control unit.
// Opcodes are RV32 instruction[6:0]; ALU-op and writeback-select encodings match the EX/WB datapath.
package ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [2:0] ALU_OP_ADD   = 3'b000;
  localparam logic [2:0] ALU_OP_BCMP  = 3'b001;
  localparam logic [2:0] ALU_OP_RFN   = 3'b010;
  localparam logic [2:0] ALU_OP_JMP   = 3'b011;
  localparam logic [2:0] ALU_OP_IFN   = 3'b100;
  localparam logic [2:0] ALU_OP_PASSB = 3'b101;

  localparam logic [1:0] WB_SEL_ALU = 2'b00;
  localparam logic [1:0] WB_SEL_MEM = 2'b01;
  localparam logic [1:0] WB_SEL_PC4 = 2'b10;

  typedef struct packed {
    logic       alu_src;
    logic       alu_a_pc;
    logic       branch;
    logic       jump;
    logic       illegal;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] wb_sel;
    logic [2:0] alu_op;
  } ctrl_bundle_t;

  // Only the fields still needed downstream are carried past EX.
  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] wb_sel;
  } mem_ctrl_t;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] wb_sel;
  } wb_ctrl_t;

endpackage

// File: rtl/ctrl_decode.sv
// Pure combinational ID-stage decoder: opcode -> control bundle plus source-register usage.
// Unknown opcodes yield an all-zero bundle with illegal set.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int EN_UPPER   = 1
) (
  input  logic [6:0]            opcode,
  input  logic [REG_ADDR_W-1:0] rd,
  output ctrl_bundle_t          ctrl,
  output logic                  uses_rs1,
  output logic                  uses_rs2
);

  always_comb begin
    ctrl     = '0;
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    case (opcode)
      OP_R: begin
        ctrl.alu_op = ALU_OP_RFN; ctrl.reg_write = 1'b1; ctrl.wb_sel = WB_SEL_ALU;
        uses_rs1 = 1'b1; uses_rs2 = 1'b1;
      end
      OP_I: begin
        ctrl.alu_src = 1'b1; ctrl.alu_op = ALU_OP_IFN; ctrl.reg_write = 1'b1;
        ctrl.wb_sel = WB_SEL_ALU; uses_rs1 = 1'b1;
      end
      OP_LOAD: begin
        ctrl.alu_src = 1'b1; ctrl.mem_read = 1'b1; ctrl.reg_write = 1'b1;
        ctrl.wb_sel = WB_SEL_MEM; ctrl.alu_op = ALU_OP_ADD; uses_rs1 = 1'b1;
      end
      OP_STORE: begin
        ctrl.alu_src = 1'b1; ctrl.mem_write = 1'b1; ctrl.alu_op = ALU_OP_ADD;
        uses_rs1 = 1'b1; uses_rs2 = 1'b1;
      end
      OP_BRANCH: begin
        ctrl.branch = 1'b1; ctrl.alu_op = ALU_OP_BCMP;
        uses_rs1 = 1'b1; uses_rs2 = 1'b1;
      end
      OP_JAL: begin
        ctrl.jump = 1'b1; ctrl.reg_write = 1'b1; ctrl.wb_sel = WB_SEL_PC4;
        ctrl.alu_op = ALU_OP_JMP;
      end
      OP_JALR: begin
        ctrl.jump = 1'b1; ctrl.alu_src = 1'b1; ctrl.reg_write = 1'b1;
        ctrl.wb_sel = WB_SEL_PC4; ctrl.alu_op = ALU_OP_JMP; uses_rs1 = 1'b1;
      end
      OP_LUI: begin
        if (EN_UPPER != 0) begin
          ctrl.alu_src = 1'b1; ctrl.alu_op = ALU_OP_PASSB; ctrl.reg_write = 1'b1;
          ctrl.wb_sel = WB_SEL_ALU;
        end else begin
          ctrl.illegal = 1'b1;
        end
      end
      OP_AUIPC: begin
        if (EN_UPPER != 0) begin
          ctrl.alu_src = 1'b1; ctrl.alu_a_pc = 1'b1; ctrl.alu_op = ALU_OP_ADD;
          ctrl.reg_write = 1'b1; ctrl.wb_sel = WB_SEL_ALU;
        end else begin
          ctrl.illegal = 1'b1;
        end
      end
      default: ctrl.illegal = 1'b1;
    endcase
    // x0 is hardwired; never request a write to it.
    if (rd == '0) ctrl.reg_write = 1'b0;
  end

endmodule

// File: rtl/pipe_control_unit.sv
// Pipelined control unit: decodes ID, carries controls through ID/EX, EX/MEM, MEM/WB,
// inserts bubbles on load-use hazards and taken branches, and counts them.
module pipe_control_unit
  import ctrl_pkg::*;
#(
  parameter int ALU_OP_W   = 3,
  parameter int REG_ADDR_W = 5,
  parameter int EN_UPPER   = 1,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [6:0]            id_opcode,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  stall_ext,
  input  logic                  flush_ex,
  output logic                  hazard_stall,
  output logic                  ex_valid,
  output logic                  ex_alu_src,
  output logic                  ex_alu_a_pc,
  output logic                  ex_branch,
  output logic                  ex_jump,
  output logic                  ex_illegal,
  output logic [ALU_OP_W-1:0]   ex_alu_op,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic                  mem_valid,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic                  mem_reg_write,
  output logic [REG_ADDR_W-1:0] mem_rd,
  output logic                  wb_valid,
  output logic                  wb_reg_write,
  output logic [1:0]            wb_sel,
  output logic [REG_ADDR_W-1:0] wb_rd,
  output logic [CNT_W-1:0]      bubble_count
);

  localparam int STAGES = 3;

  ctrl_bundle_t          dec, ex_q;
  mem_ctrl_t             mem_q;
  wb_ctrl_t              wb_q;
  logic [STAGES:1]       vld_pipe;
  logic [REG_ADDR_W-1:0] ex_rd_q, mem_rd_q, wb_rd_q;
  logic                  uses_rs1, uses_rs2, kill;

  ctrl_decode #(.REG_ADDR_W(REG_ADDR_W), .EN_UPPER(EN_UPPER)) u_dec (
    .opcode   (id_opcode),
    .rd       (id_rd),
    .ctrl     (dec),
    .uses_rs1 (uses_rs1),
    .uses_rs2 (uses_rs2)
  );

  // Load in EX whose result an ID source needs: hold ID one cycle and bubble EX.
  assign hazard_stall = id_valid & vld_pipe[1] & ex_q.mem_read & (ex_rd_q != '0) &
                        ((uses_rs1 & (ex_rd_q == id_rs1)) | (uses_rs2 & (ex_rd_q == id_rs2)));
  assign kill = flush_ex | hazard_stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe     <= '0;
      ex_q         <= '0;
      ex_rd_q      <= '0;
      mem_q        <= '0;
      mem_rd_q     <= '0;
      wb_q         <= '0;
      wb_rd_q      <= '0;
      bubble_count <= '0;
    end else if (!stall_ext) begin
      vld_pipe[STAGES:2] <= vld_pipe[STAGES-1:1];
      mem_q    <= '{mem_read: ex_q.mem_read, mem_write: ex_q.mem_write,
                    reg_write: ex_q.reg_write, wb_sel: ex_q.wb_sel};
      mem_rd_q <= ex_rd_q;
      wb_q     <= '{reg_write: mem_q.reg_write, wb_sel: mem_q.wb_sel};
      wb_rd_q  <= mem_rd_q;
      if (kill) begin
        vld_pipe[1] <= 1'b0;
        ex_q        <= '0;
        ex_rd_q     <= '0;
        if (bubble_count != '1) bubble_count <= bubble_count + CNT_W'(1);
      end else begin
        vld_pipe[1] <= id_valid;
        ex_q        <= id_valid ? dec : '0;
        ex_rd_q     <= id_valid ? id_rd : '0;
      end
    end
  end

  assign ex_valid      = vld_pipe[1];
  assign ex_alu_src    = ex_q.alu_src;
  assign ex_alu_a_pc   = ex_q.alu_a_pc;
  assign ex_branch     = ex_q.branch;
  assign ex_jump       = ex_q.jump;
  assign ex_illegal    = ex_q.illegal;
  assign ex_alu_op     = ALU_OP_W'(ex_q.alu_op);
  assign ex_rd         = ex_rd_q;
  assign mem_valid     = vld_pipe[2];
  assign mem_read      = mem_q.mem_read;
  assign mem_write     = mem_q.mem_write;
  assign mem_reg_write = mem_q.reg_write;
  assign mem_rd        = mem_rd_q;
  assign wb_valid      = vld_pipe[3];
  assign wb_reg_write  = wb_q.reg_write;
  assign wb_sel        = wb_q.wb_sel;
  assign wb_rd         = wb_rd_q;

endmodule

// File: tb/tb_pipe_control_unit.sv
// Scoreboard bench: an instruction-level pipeline model predicts every cycle's outputs for two
// instances (upper ops on / 16-bit counter, upper ops off / 3-bit counter); a monitor compares at negedge.
module tb_pipe_control_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       id_valid = 1'b0, stall_ext = 1'b0, flush_ex = 1'b0;
  logic [6:0] id_opcode = '0;
  logic [4:0] id_rd = '0, id_rs1 = '0, id_rs2 = '0;

  always #5 clk = ~clk;

  typedef struct packed {
    logic       hz, exv, src, apc, br, jmp, ill;
    logic [2:0] aluop;
    logic [4:0] exrd;
    logic       memv, mr, mw, mrw;
    logic [4:0] memrd;
    logic       wbv, wrw;
    logic [1:0] ws;
    logic [4:0] wbrd;
    logic [15:0] cnt;
  } obs_t;

  typedef struct packed {
    logic src, apc, br, jmp, ill, mr, mw, rw;
    logic [1:0] ws;
    logic [2:0] op;
  } tctl_t;

  typedef struct packed {
    logic       v;
    logic [6:0] op;
    logic [4:0] rd, rs1, rs2;
  } instr_t;

  obs_t o0, o1;
  logic [2:0] cnt1_raw;

  pipe_control_unit #(.ALU_OP_W(3), .REG_ADDR_W(5), .EN_UPPER(1), .CNT_W(16)) u0 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode), .id_rd(id_rd),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .stall_ext(stall_ext), .flush_ex(flush_ex),
    .hazard_stall(o0.hz), .ex_valid(o0.exv), .ex_alu_src(o0.src), .ex_alu_a_pc(o0.apc),
    .ex_branch(o0.br), .ex_jump(o0.jmp), .ex_illegal(o0.ill), .ex_alu_op(o0.aluop),
    .ex_rd(o0.exrd), .mem_valid(o0.memv), .mem_read(o0.mr), .mem_write(o0.mw),
    .mem_reg_write(o0.mrw), .mem_rd(o0.memrd), .wb_valid(o0.wbv), .wb_reg_write(o0.wrw),
    .wb_sel(o0.ws), .wb_rd(o0.wbrd), .bubble_count(o0.cnt));

  pipe_control_unit #(.ALU_OP_W(3), .REG_ADDR_W(5), .EN_UPPER(0), .CNT_W(3)) u1 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode), .id_rd(id_rd),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .stall_ext(stall_ext), .flush_ex(flush_ex),
    .hazard_stall(o1.hz), .ex_valid(o1.exv), .ex_alu_src(o1.src), .ex_alu_a_pc(o1.apc),
    .ex_branch(o1.br), .ex_jump(o1.jmp), .ex_illegal(o1.ill), .ex_alu_op(o1.aluop),
    .ex_rd(o1.exrd), .mem_valid(o1.memv), .mem_read(o1.mr), .mem_write(o1.mw),
    .mem_reg_write(o1.mrw), .mem_rd(o1.memrd), .wb_valid(o1.wbv), .wb_reg_write(o1.wrw),
    .wb_sel(o1.ws), .wb_rd(o1.wbrd), .bubble_count(cnt1_raw));
  assign o1.cnt = {13'd0, cnt1_raw};

  // ---------------- reference model ----------------
  function automatic tctl_t ctl(logic [6:0] op, logic [4:0] rd, bit en);
    tctl_t c = '0;
    case (op)
      7'h33: begin c.op = 3'd2; c.rw = 1; end
      7'h13: begin c.src = 1; c.op = 3'd4; c.rw = 1; end
      7'h03: begin c.src = 1; c.mr = 1; c.rw = 1; c.ws = 2'b01; end
      7'h23: begin c.src = 1; c.mw = 1; end
      7'h63: begin c.br = 1; c.op = 3'd1; end
      7'h6F: begin c.jmp = 1; c.rw = 1; c.ws = 2'b10; c.op = 3'd3; end
      7'h67: begin c.jmp = 1; c.src = 1; c.rw = 1; c.ws = 2'b10; c.op = 3'd3; end
      7'h37: if (en) begin c.src = 1; c.op = 3'd5; c.rw = 1; end else c.ill = 1;
      7'h17: if (en) begin c.src = 1; c.apc = 1; c.rw = 1; end else c.ill = 1;
      default: c.ill = 1;
    endcase
    if (rd == 0) c.rw = 0;
    return c;
  endfunction

  instr_t m_ex, m_mem, m_wb, cur;
  int     m_cnt0, m_cnt1;
  bit     p_rst, p_stall, p_flush, p_hz;

  function automatic bit hazard(instr_t ex, instr_t id);
    bit u1s = id.op inside {7'h33, 7'h23, 7'h63, 7'h13, 7'h03, 7'h67};
    bit u2s = id.op inside {7'h33, 7'h23, 7'h63};
    return id.v && ex.v && ex.op == 7'h03 && ex.rd != 0 &&
           ((u1s && ex.rd == id.rs1) || (u2s && ex.rd == id.rs2));
  endfunction

  function automatic obs_t expect_obs(bit en, int cnt, bit hz);
    obs_t e = '0;
    tctl_t c;
    e.hz = hz;
    if (m_ex.v) begin
      c = ctl(m_ex.op, m_ex.rd, en);
      e.exv = 1; e.src = c.src; e.apc = c.apc; e.br = c.br; e.jmp = c.jmp;
      e.ill = c.ill; e.aluop = c.op; e.exrd = m_ex.rd;
    end
    if (m_mem.v) begin
      c = ctl(m_mem.op, m_mem.rd, en);
      e.memv = 1; e.mr = c.mr; e.mw = c.mw; e.mrw = c.rw; e.memrd = m_mem.rd;
    end
    if (m_wb.v) begin
      c = ctl(m_wb.op, m_wb.rd, en);
      e.wbv = 1; e.wrw = c.rw; e.ws = c.ws; e.wbrd = m_wb.rd;
    end
    e.cnt = 16'(cnt);
    return e;
  endfunction

  // ---------------- scoreboard ----------------
  obs_t q0[$], q1[$];
  int   checks = 0, passes = 0, cyc_n = 0;

  task automatic chk(string name, obs_t got, obs_t exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc_n, got, exp);
  endtask

  initial begin
    obs_t e;
    forever begin
      @(negedge clk);
      if (q0.size() > 0) begin e = q0.pop_front(); chk("u0_outputs", o0, e); end
      if (q1.size() > 0) begin e = q1.pop_front(); chk("u1_outputs", o1, e); end
    end
  end

  // One cycle: advance the model across the edge just taken, then drive new inputs.
  task automatic cyc(bit v, logic [6:0] op, logic [4:0] rd, logic [4:0] r1, logic [4:0] r2,
                     bit st, bit fl, bit r);
    instr_t ni;
    @(posedge clk); #1;
    cyc_n++;
    if (p_rst) begin
      m_ex = '0; m_mem = '0; m_wb = '0; m_cnt0 = 0; m_cnt1 = 0;
    end else if (!p_stall) begin
      m_wb = m_mem; m_mem = m_ex;
      if (p_flush || p_hz) begin
        m_ex = '0;
        if (m_cnt0 < 65535) m_cnt0++;
        if (m_cnt1 < 7) m_cnt1++;
      end else m_ex = cur.v ? cur : '0;
    end
    ni = '{v: v, op: op, rd: rd, rs1: r1, rs2: r2};
    cur = ni;
    id_valid = v; id_opcode = op; id_rd = rd; id_rs1 = r1; id_rs2 = r2;
    stall_ext = st; flush_ex = fl; rst = r;
    if (r) begin
      m_ex = '0; m_mem = '0; m_wb = '0; m_cnt0 = 0; m_cnt1 = 0;
    end
    p_rst = r; p_stall = st; p_flush = fl;
    p_hz = r ? 1'b0 : hazard(m_ex, ni);
    q0.push_back(expect_obs(1'b1, m_cnt0, p_hz));
    q1.push_back(expect_obs(1'b0, m_cnt1, p_hz));
  endtask

  logic [6:0] ops [12];

  initial begin
    bit hold;
    logic [6:0] op;
    logic [4:0] rd, r1, r2;
    bit v;
    ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17,
            7'h03, 7'h03, 7'h7F};
    m_ex = '0; m_mem = '0; m_wb = '0; cur = '0; m_cnt0 = 0; m_cnt1 = 0;
    p_rst = 1; p_stall = 0; p_flush = 0; p_hz = 0;

    cyc(0, 0, 0, 0, 0, 0, 0, 1);             // reset state
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    cyc(1, 7'h33, 5, 1, 2, 0, 0, 0);         // R-type rd=5
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 7'h03, 3, 1, 0, 0, 0, 0);         // lw x3
    cyc(1, 7'h33, 6, 3, 4, 0, 0, 0);         // add uses x3 -> hazard
    cyc(1, 7'h33, 6, 3, 4, 0, 0, 0);         // re-presented
    cyc(1, 7'h03, 0, 1, 0, 0, 0, 0);         // lw x0
    cyc(1, 7'h33, 7, 0, 2, 0, 0, 0);         // no hazard on x0
    cyc(1, 7'h63, 0, 1, 2, 0, 0, 0);         // beq
    cyc(1, 7'h33, 8, 1, 2, 0, 1, 0);         // flush kills add
    cyc(1, 7'h13, 9, 1, 0, 0, 0, 0);
    cyc(1, 7'h33, 10, 1, 2, 1, 1, 0);        // flush+stall: all hold
    cyc(1, 7'h33, 10, 1, 2, 1, 0, 0);        // stall 3 cycles
    cyc(1, 7'h33, 10, 1, 2, 1, 0, 0);
    cyc(1, 7'h33, 10, 1, 2, 0, 0, 0);
    cyc(1, 7'h37, 11, 0, 0, 0, 0, 0);        // LUI
    cyc(1, 7'h17, 12, 0, 0, 0, 0, 0);        // AUIPC
    cyc(1, 7'h6F, 1, 0, 0, 0, 0, 0);
    cyc(1, 7'h67, 2, 5, 0, 0, 0, 1);         // reset mid-stream
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 12; k++)             // drive the 3-bit counter into saturation
      cyc(1, 7'h33, 1, 2, 3, 0, 1, 0);

    hold = 0; v = 0; op = 0; rd = 0; r1 = 0; r2 = 0;
    for (int i = 0; i < 600; i++) begin
      if (!hold) begin
        v  = ($urandom_range(0, 9) != 0);
        op = ops[$urandom_range(0, 11)];
        if (op == 7'h7F) op = 7'($urandom);
        rd = 5'($urandom_range(0, 3)); r1 = 5'($urandom_range(0, 3)); r2 = 5'($urandom_range(0, 3));
      end
      cyc(v, op, rd, r1, r2, ($urandom_range(0, 6) == 0), ($urandom_range(0, 9) == 0),
          ($urandom_range(0, 149) == 0));
      hold = !rst && (stall_ext || (p_hz && !flush_ex));
    end
    cyc(0, 0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 10 && (q0.size() > 0 || q1.size() > 0); i++) @(negedge clk);
    #1;
    if (q0.size() > 0 || q1.size() > 0) begin
      checks++;
      $display("FAIL scoreboard_drain got=%0d pending expected=0", q0.size() + q1.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
